// File: rtl/mips_pkg.sv
// mips_pkg: CPU state and memory access size types shared by the control path and bus bridge.
package mips_pkg;
  typedef enum logic [1:0] {FETCH, EXEC1, EXEC2, HALT} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_WLR} mem_size_t;
endpackage

// File: rtl/mips_mem_bridge_if.sv
// mips_mem_bridge_if: Avalon-MM master bus between the CPU bridge and external memory.
interface mips_mem_bridge_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] address;
  logic read;
  logic write;
  logic [3:0] byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic waitrequest;
  modport master(output address, read, write, byteenable, writedata, input readdata, waitrequest);
  modport slave(input address, read, write, byteenable, writedata, output readdata, waitrequest);
endinterface

// File: rtl/mips_byte_lane.sv
// mips_byte_lane: byte enables, store lane replication, load extraction/extension and alignment check.
module mips_byte_lane
  import mips_pkg::*;
(
  input  logic [1:0]  lo,
  input  mem_size_t   size,
  input  logic [31:0] wdata,
  input  logic [1:0]  ld_lo,
  input  mem_size_t   ld_size,
  input  logic        ld_signed,
  input  logic [31:0] rdata,
  output logic        aligned,
  output logic [3:0]  be,
  output logic [31:0] wrep,
  output logic [31:0] ext
);
  logic [31:0] sh;
  always_comb begin
    aligned = size == SZ_BYTE || (size == SZ_HALF ? !lo[0] : lo == 2'b00);
    be = size == SZ_BYTE ? 4'b0001 << lo : size == SZ_HALF ? 4'b0011 << lo : 4'b1111;
    wrep = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    sh = rdata >> {ld_lo, 3'b000};
    ext = ld_size == SZ_BYTE ? {{24{ld_signed & sh[7]}}, sh[7:0]}
        : ld_size == SZ_HALF ? {{16{ld_signed & sh[15]}}, sh[15:0]} : rdata;
  end
endmodule

// File: rtl/mips_mem_bridge.sv
// mips_mem_bridge: Avalon-MM master issuing CPU fetches and data accesses with a qualified stall.
module mips_mem_bridge
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  state_t            state,
  input  logic [ADDR_W-1:0] pc,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  mem_size_t         mem_size,
  input  logic              mem_signed,
  output logic [31:0]       instr,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              misalign,
  mips_mem_bridge_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} bus_t;
  bus_t fsm, fsm_n;
  state_t cap_state;
  logic fetch_q, sign_q;
  logic [1:0] lo_q;
  mem_size_t size_q, req_size;
  logic [ADDR_W-1:0] req_addr;
  logic is_fetch, want, free, start, bad, done, aligned;
  logic [3:0] be;
  logic [31:0] wrep, ext;

  assign req_addr = is_fetch ? pc : mem_addr;
  assign req_size = is_fetch ? SZ_WORD : mem_size;

  mips_byte_lane lane (
    .lo(req_addr[1:0]), .size(req_size), .wdata(mem_wdata),
    .ld_lo(lo_q), .ld_size(size_q), .ld_signed(sign_q), .rdata(bus.readdata),
    .aligned(aligned), .be(be), .wrep(wrep), .ext(ext)
  );

  // DONE behaves like IDLE once the CPU leaves the state that launched the access,
  // so a back-to-back request is issued without an extra unstalled cycle.
  always_comb begin
    is_fetch = state == FETCH;
    want = is_fetch || (state == EXEC1 && (mem_read || mem_write));
    free = fsm == IDLE || (fsm == DONE && state != cap_state);
    start = free && want && aligned;
    bad = free && want && !aligned;
    done = fsm == BUSY && !bus.waitrequest;
    fsm_n = start ? BUSY : done ? DONE : free ? IDLE : fsm;
    stall = !rst && (start || (fsm == BUSY && bus.waitrequest));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= IDLE;
      cap_state <= FETCH;
      fetch_q <= 1'b0;
      sign_q <= 1'b0;
      lo_q <= 2'b00;
      size_q <= SZ_BYTE;
      misalign <= 1'b0;
      instr <= '0;
      load_data <= '0;
      bus.address <= '0;
      bus.read <= 1'b0;
      bus.write <= 1'b0;
      bus.byteenable <= '0;
      bus.writedata <= '0;
    end else begin
      fsm <= fsm_n;
      if (bad) misalign <= 1'b1;
      if (start) begin
        cap_state <= state;
        fetch_q <= is_fetch;
        sign_q <= mem_signed;
        lo_q <= req_addr[1:0];
        size_q <= req_size;
        bus.address <= {req_addr[ADDR_W-1:2], 2'b00};
        bus.read <= is_fetch || mem_read;
        bus.write <= !is_fetch && mem_write;
        bus.byteenable <= be;
        bus.writedata <= is_fetch ? '0 : wrep;
      end
      if (done) begin
        bus.read <= 1'b0;
        bus.write <= 1'b0;
        if (fetch_q) instr <= bus.readdata;
        else if (bus.read) load_data <= ext;
      end
    end
  end
endmodule

// File: tb/tb_mips_mem_bridge.sv
// tb_mips_mem_bridge: CPU/memory emulation with a reference-model scoreboard for the bus bridge.
module tb_mips_mem_bridge;
  import mips_pkg::*;
  typedef struct {
    int kind;
    logic [31:0] addr, wd, res, rdata;
    logic rd, wr;
    logic [3:0] be;
    int wt;
  } exp_t;

  logic clk = 0, rst = 1;
  state_t state = HALT;
  logic [31:0] pc = 0, mem_addr = 0, mem_wdata = 0;
  logic mem_read = 0, mem_write = 0, mem_signed = 0;
  mem_size_t mem_size = SZ_WORD;
  logic [31:0] instr, load_data;
  logic stall, misalign;
  int checks = 0, errors = 0, wc = -1;
  bit mon_en = 1, pend_v = 0;
  exp_t expq[$];
  exp_t pend;

  mips_mem_bridge_if bus ();
  mips_mem_bridge dut (
    .clk(clk), .rst(rst), .state(state), .pc(pc), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_signed(mem_signed),
    .instr(instr), .load_data(load_data), .stall(stall), .misalign(misalign), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Byte-level view: an access covers bytes off..off+n-1 of the addressed word.
  function automatic exp_t model(int kind, logic [31:0] a, logic [1:0] sz, logic sg,
                                 logic [31:0] wd, logic [31:0] rdat, int wt);
    exp_t e;
    int n, off;
    longint v;
    n = sz == 0 ? 1 : sz == 1 ? 2 : 4;
    off = int'(a[1:0]);
    e.kind = kind; e.addr = a & ~32'd3; e.rd = kind != 2; e.wr = kind == 2;
    e.rdata = rdat; e.wt = wt; e.be = 0; e.wd = 0; v = 0;
    for (int b = 0; b < 4; b++) begin
      e.be[b] = b >= off && b < off + n;
      e.wd[8*b +: 8] = wd[8*(b % n) +: 8];
    end
    for (int i = 0; i < n; i++) v = v | (longint'(rdat[8*(off+i) +: 8]) << (8*i));
    if (sg && n < 4 && v >= (64'sd1 << (8*n-1))) v = v - (64'sd1 << (8*n));
    e.res = v[31:0];
    return e;
  endfunction

  task automatic access(input state_t st, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [1:0] sz, input logic sg, input logic [31:0] wd,
                        input logic [31:0] rdat, input int wt);
    bit acc;
    logic s;
    int cyc;
    @(negedge clk);
    acc = st == FETCH || (st == EXEC1 && (rd || wr));
    state = st;
    mem_read = st == EXEC1 && rd;
    mem_write = st == EXEC1 && wr;
    mem_size = mem_size_t'(sz);
    mem_signed = sg;
    mem_wdata = wd;
    if (st == FETCH) pc = a; else mem_addr = a;
    if (acc) expq.push_back(model(st == FETCH ? 0 : rd ? 1 : 2, a, st == FETCH ? 2'd2 : sz, sg, wd, rdat, wt));
    s = 1;
    for (cyc = 1; cyc <= 30; cyc++) begin
      #1 s = stall;
      if (cyc == 1 && acc) chk("stall_first", {31'd0, s}, 32'd1);
      @(posedge clk);
      if (!s) break;
      @(negedge clk);
    end
    chk("state_cycles", cyc, acc ? 2 + wt : 1);
  endtask

  // Memory slave: per-transaction wait count, random waitrequest/readdata while idle.
  always @(negedge clk) begin
    if (bus.read || bus.write) begin
      if (wc < 0) wc = expq.size() > 0 ? expq[0].wt : 0;
      bus.readdata = expq.size() > 0 ? expq[0].rdata : $urandom;
      if (wc == 0) bus.waitrequest = 1'b0;
      else begin
        bus.waitrequest = 1'b1;
        wc--;
      end
    end else begin
      wc = -1;
      bus.waitrequest = 1'($urandom_range(0, 1));
      bus.readdata = $urandom;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (mon_en) begin
      if (pend_v) begin
        if (pend.kind == 0) chk("instr", instr, pend.res);
        else chk("load_data", load_data, pend.res);
        pend_v = 0;
      end
      if (bus.read || bus.write) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_request: addr %h read %b write %b, none expected", bus.address, bus.read, bus.write);
        end else begin
          e = expq[0];
          chk("address", bus.address, e.addr);
          chk("read", {31'd0, bus.read}, {31'd0, e.rd});
          chk("write", {31'd0, bus.write}, {31'd0, e.wr});
          chk("byteenable", {28'd0, bus.byteenable}, {28'd0, e.be});
          if (e.wr) chk("writedata", bus.writedata, e.wd);
          chk("stall_busy", {31'd0, stall}, {31'd0, bus.waitrequest});
          if (!bus.waitrequest) begin
            void'(expq.pop_front());
            if (e.kind != 2) begin
              pend = e;
              pend_v = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [1:0] sz;
    int k;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read", {31'd0, bus.read}, 0);
    chk("rst_be", {28'd0, bus.byteenable}, 0);
    chk("rst_instr", instr, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_misalign", {31'd0, misalign}, 0);
    rst = 0;
    access(FETCH, 0, 0, 32'h10, 2, 0, 0, 32'h2402_0005, 0);
    access(EXEC1, 0, 0, 0, 2, 0, 0, 0, 0);
    access(FETCH, 0, 0, 32'h14, 2, 0, 0, $urandom, 3);
    access(EXEC1, 1, 0, 32'h103, 0, 1, 0, 32'h80FF_FF7F, 0);
    access(EXEC2, 0, 0, 0, 0, 0, 0, 0, 0);
    access(FETCH, 0, 0, 32'h18, 2, 0, 0, $urandom, 1);
    access(EXEC1, 0, 1, 32'h202, 1, 0, 32'h0000_BEEF, 0, 0);
    access(EXEC2, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      access(FETCH, 0, 0, $urandom & ~32'd3, 2, 0, 0, $urandom, $urandom_range(0, 3));
      k = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if (sz == 1) a[0] = 0;
      if (sz >= 2) a[1:0] = 0;
      access(EXEC1, k == 1, k == 2, a, sz, 1'($urandom), $urandom, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 1)) access(EXEC2, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    access(HALT, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #3;
    chk("queue_drained", expq.size(), 0);
    // Reset in the middle of a stalled fetch.
    state = FETCH;
    pc = 32'h40;
    expq.push_back(model(0, 32'h40, 2, 0, 0, 0, 8));
    repeat (3) @(negedge clk);
    mon_en = 0;
    #3;
    chk("busy_read_before_rst", {31'd0, bus.read}, 1);
    rst = 1;
    @(posedge clk);
    #1;
    chk("rst_mid_read", {31'd0, bus.read}, 0);
    chk("rst_mid_addr", bus.address, 0);
    chk("rst_mid_be", {28'd0, bus.byteenable}, 0);
    chk("rst_mid_wdata", bus.writedata, 0);
    chk("rst_mid_stall", {31'd0, stall}, 0);
    chk("rst_mid_instr", instr, 0);
    @(negedge clk);
    rst = 0;
    expq.delete();
    state = EXEC1;
    mem_read = 1;
    mem_write = 0;
    mem_addr = 32'h6;
    mem_size = SZ_WORD;
    #1 chk("misalign_stall", {31'd0, stall}, 0);
    chk("misalign_pre", {31'd0, misalign}, 0);
    @(posedge clk);
    #1 chk("misalign_set", {31'd0, misalign}, 1);
    chk("misalign_noread", {31'd0, bus.read}, 0);
    @(negedge clk);
    state = HALT;
    mem_read = 0;
    repeat (3) @(posedge clk);
    #1 chk("misalign_sticky", {31'd0, misalign}, 1);
    chk("halt_noread", {31'd0, bus.read | bus.write}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_mem_bridge.md
# mips_mem_bridge

Avalon-MM master port of the MIPS CPU, sitting between the CPU datapath/control and the external memory bus. It issues the instruction fetch in FETCH and the data load or store in EXEC1, holds requests stable across `waitrequest`, and captures the instruction register and load data. It also generates byte enables and load alignment/extension, and gives the state machine a qualified stall (`stall`) to use in place of raw bus `waitrequest`.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width on both sides.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `state` in 2: CPU state (`FETCH`=0, `EXEC1`=1, `EXEC2`=2, `HALT`=3).
- `pc` in 32: fetch address, word-aligned.
- `mem_read` / `mem_write` in 1 each: EXEC1 data access request; never both high.
- `mem_addr` in 32: data byte address.
- `mem_wdata` in 32: store data, right-justified.
- `mem_size` in 2: 0=byte, 1=half, 2=word, 3=word-left/right unused (treated as word).
- `mem_signed` in 1: sign-extend sub-word loads.
- `instr` out 32: instruction register.
- `load_data` out 32: aligned, extended load result.
- `stall` out 1: to state machine `waitrequest`.
- `misalign` out 1: registered alignment fault, to control (drives `Halt`).
- `address` out 32, `read` out 1, `write` out 1, `byteenable` out 4, `writedata` out 32: Avalon master outputs.
- `readdata` in 32, `waitrequest` in 1: Avalon master inputs.

## Operation
- Internal FSM `IDLE`, `BUSY`, `DONE`; resets to `IDLE`.
- `IDLE` + `state==FETCH` -> `BUSY`, fetch request at `pc`.
- `IDLE` + `state==EXEC1` + (`mem_read`|`mem_write`) + aligned -> `BUSY`, data request.
- `BUSY`: `read`/`write`, `address`, `byteenable`, `writedata` held constant while `waitrequest`=1. On a cycle with `waitrequest`=0 the transfer completes: fetch loads `instr<=readdata`, load loads `load_data` (aligned/extended) -> `DONE`.
- `DONE` -> `IDLE` when `state` changes from the value captured at request start; no second access is issued in the same state.
- `address` is the word address (low two bits 0).
- `byteenable`: byte `4'b0001<<addr[1:0]`; half `4'b0011<<addr[1:0]`; word `4'b1111`.
- `writedata`: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
- Load extraction: select lane by `addr[1:0]`; zero- or sign-extend per `mem_signed`.
- Misalignment (half with `addr[0]`=1; word with `addr[1:0]`!=0; fetch with `pc[1:0]`!=0): no bus request, `misalign`<=1 next cycle, FSM stays `IDLE`. `misalign` is sticky until `rst`.
- `stall` = `BUSY` & `waitrequest` (combinational). Raw `waitrequest` outside `BUSY` is ignored.
- `state==HALT` or `EXEC2`: no new requests. A `BUSY` transfer still completes per Avalon rules, since the master must not drop `read`/`write`.
- Reset mid-transfer: `rst` wins; `read`/`write` drop next edge (permitted abort at CPU reset).

## Timing
- Reset values: FSM `IDLE`; `read`,`write`,`misalign`,`stall` 0; `byteenable` 0; `address`,`writedata`,`instr`,`load_data` 0.
- Request outputs are registered. `read`/`write` assert 1 cycle after entering FETCH/EXEC1.
- Because outputs are registered, `stall` is forced to 1 on the first cycle of FETCH/EXEC1-with-access (request not yet issued). This keeps the state machine in place.
- Zero-wait-state access: FETCH lasts 2 cycles; `instr` valid the cycle after completion.
- Each additional `waitrequest` cycle adds 1 cycle.
- Fixed read latency 0: `readdata` is sampled in the completion cycle.

## Structure
- Shared package `mips_pkg` holds `state_t` (moved out of the state machine file) and `mem_size_t`. Both are imported here and by the state machine.
- Sub-module `mips_byte_lane`: combinational byteenable, write replication, load extraction and extension, and the alignment check.

## Test plan
- Fetch, `pc`=0x0000_0010, `readdata`=0x2402_0005, `waitrequest`=0 -> `read` high 1 cycle at `address` 0x10; `instr`=0x2402_0005.
- Fetch with `waitrequest` high 3 cycles -> `address`/`read` stable for 4 cycles; `stall` high throughout; single completion.
- Signed byte load, `addr`=0x103, `readdata`=0x80FF_FF7F -> `byteenable`=4'b1000; `load_data`=0xFFFF_FF80.
- Half store, `addr`=0x202, `mem_wdata`=0x0000_BEEF -> `writedata`=0xBEEF_BEEF, `byteenable`=4'b1100, `write` for 1 cycle.
- Word load at `addr`=0x6 -> no `read`; `misalign`=1 next cycle and stays 1.
- `rst` asserted during a `BUSY` with `waitrequest`=1 -> all outputs at reset values next edge.
